// File: rtl/seq_detect_pkg.sv
// Shared definitions for the serial pattern detector.
//   state_width(width) : bits needed to hold a prefix length 0..width
//   OVERLAP_ON/OFF     : matching-mode selectors for the OVERLAP parameter
package seq_detect_pkg;

  localparam bit OVERLAP_ON  = 1'b1;
  localparam bit OVERLAP_OFF = 1'b0;

  function automatic int unsigned state_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_prefix_match.sv
// Combinational prefix matcher.
// Ports:
//   hist    in  WIDTH  accepted history, newest bit in LSB
//   a       in  1      incoming bit
//   fill    in  SW     number of valid bits in hist
//   pattern in  WIDTH  active pattern, MSB expected first
//   k       out SW     longest pattern prefix ending at the incoming bit
//   hit     out 1      k equals WIDTH (full match)
module seq_prefix_match
  import seq_detect_pkg::*;
#(
  parameter  int unsigned WIDTH = 4,
  localparam int unsigned SW    = state_width(WIDTH)
) (
  input  logic [WIDTH-1:0] hist,
  input  logic             a,
  input  logic [SW-1:0]    fill,
  input  logic [WIDTH-1:0] pattern,
  output logic [SW-1:0]    k,
  output logic             hit
);

  logic [WIDTH-1:0] w_new;
  logic [WIDTH-1:0] w_mask;
  int unsigned      w_fill;
  int unsigned      w_limit;

  always_comb begin
    w_new   = {hist[WIDTH-2:0], a};
    w_fill  = 32'(fill);
    w_limit = (w_fill >= WIDTH) ? WIDTH : w_fill + 1;
    w_mask  = '0;
    k       = '0;
    // Ascending scan: the last length that matches is the longest one.
    // The newest n bits are compared against the top n pattern bits,
    // right-aligned by shifting the pattern down.
    for (int unsigned n = 1; n <= WIDTH; n++) begin
      w_mask = '1;
      w_mask = w_mask >> (WIDTH - n);
      if ((n <= w_limit) && ((w_new & w_mask) == (pattern >> (WIDTH - n))))
        k = SW'(n);
    end
    hit = (k == SW'(WIDTH));
  end

endmodule

// File: rtl/seq_pattern_detector.sv
// Parametrised serial pattern detector with loadable pattern, overlap or
// non-overlap matching, input-valid qualifier and saturating match counter.
// Ports:
//   clock        in  1            rising-edge clock
//   clear        in  1            synchronous active-high reset
//   a            in  1            serial data bit
//   a_valid      in  1            a is sampled only when high
//   pattern_load in  1            load pattern_in (discards a this cycle)
//   pattern_in   in  WIDTH        new pattern, MSB expected first
//   x            out 1            registered one-cycle match pulse
//   match_count  out COUNT_WIDTH  saturating match count
//   state        out SW           matched-prefix length 0..WIDTH
//   pattern      out WIDTH        active pattern
module seq_pattern_detector
  import seq_detect_pkg::*;
#(
  parameter  int unsigned      WIDTH           = 4,
  parameter  logic [WIDTH-1:0] DEFAULT_PATTERN = 4'b1011,
  parameter  bit               OVERLAP         = OVERLAP_ON,
  parameter  int unsigned      COUNT_WIDTH     = 8,
  localparam int unsigned      SW              = state_width(WIDTH)
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic                   a,
  input  logic                   a_valid,
  input  logic                   pattern_load,
  input  logic [WIDTH-1:0]       pattern_in,
  output logic                   x,
  output logic [COUNT_WIDTH-1:0] match_count,
  output logic [SW-1:0]          state,
  output logic [WIDTH-1:0]       pattern
);

  logic [WIDTH-1:0]       r_hist;
  logic [SW-1:0]          r_fill;
  logic [SW-1:0]          r_state;
  logic                   r_x;
  logic [COUNT_WIDTH-1:0] r_count;
  logic [WIDTH-1:0]       r_pattern;

  logic [SW-1:0]          w_k;
  logic                   w_hit;

  seq_prefix_match #(
    .WIDTH (WIDTH)
  ) u_match (
    .hist    (r_hist),
    .a       (a),
    .fill    (r_fill),
    .pattern (r_pattern),
    .k       (w_k),
    .hit     (w_hit)
  );

  always_ff @(posedge clock) begin
    if (clear) begin
      r_hist    <= '0;
      r_fill    <= '0;
      r_state   <= '0;
      r_x       <= 1'b0;
      r_count   <= '0;
      r_pattern <= DEFAULT_PATTERN;
    end else if (pattern_load) begin
      r_pattern <= pattern_in;
      r_hist    <= '0;
      r_fill    <= '0;
      r_state   <= '0;
      r_x       <= 1'b0;
    end else if (a_valid) begin
      r_hist  <= {r_hist[WIDTH-2:0], a};
      r_state <= w_k;
      r_x     <= w_hit;
      if (w_hit && (r_count != '1))
        r_count <= r_count + 1'b1;
      // Non-overlap forgets the history by zeroing fill; hist itself is
      // left alone because fill alone bounds what the matcher may use.
      if (w_hit && (OVERLAP == OVERLAP_OFF))
        r_fill <= '0;
      else if (r_fill != SW'(WIDTH))
        r_fill <= r_fill + 1'b1;
    end else begin
      r_x <= 1'b0;
    end
  end

  assign x           = r_x;
  assign match_count = r_count;
  assign state       = r_state;
  assign pattern     = r_pattern;

endmodule
